// File: rtl/match_collector.sv
// match_collector: drives a pattern searcher over an address range and queues match locations in a FIFO.
module match_collector #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic [15:0] seq_start,
  input  logic [15:0] seq_end,
  output logic        srch_ready,
  output logic [15:0] srch_start,
  input  logic        srch_done,
  input  logic        srch_found,
  input  logic        srch_error,
  input  logic [15:0] srch_location,
  input  logic        pop,
  output logic        loc_valid,
  output logic [15:0] loc_out,
  output logic [4:0]  fifo_count,
  output logic [7:0]  match_count,
  output logic        busy,
  output logic        job_done,
  output logic        overflow,
  output logic        err_flag
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STORE, FINISH} state_t;
  state_t state_q, state_d;
  logic [15:0] next_q, next_d, end_q, end_d, loc_q, loc_d;
  logic [7:0] mc_q, mc_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [4:0] cnt_q, cnt_d;
  logic ready_q, done_q, busy_q;
  logic push, pop_ok, full;
  logic [15:0] mem [DEPTH];
  assign pop_ok = pop && cnt_q != 5'd0;
  assign full = cnt_q == 5'(DEPTH);
  always_comb begin
    state_d = state_q;
    next_d = next_q;
    end_d = end_q;
    loc_d = loc_q;
    mc_d = mc_q;
    ovf_d = ovf_q;
    err_d = err_q;
    push = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        next_d = seq_start;
        end_d = seq_end;
        mc_d = 8'd0;
        ovf_d = 1'b0;
        err_d = 1'b0;
        state_d = seq_start > seq_end ? FINISH : LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (srch_done) begin
        err_d = err_q | srch_error;
        loc_d = srch_location;
        state_d = (!srch_error && srch_found) ? STORE : FINISH;
      end
      STORE: begin
        mc_d = mc_q + 8'(mc_q != 8'hFF);
        push = !full || pop_ok;
        ovf_d = ovf_q | ~push;
        next_d = loc_q + 16'd1;
        state_d = (loc_q >= end_q || loc_q == 16'hFFFF) ? FINISH : LAUNCH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a new job flushes the queue even if the host pops in the same cycle
    wp_d = (state_q == IDLE && go) ? '0 : wp_q + AW'(push);
    rp_d = (state_q == IDLE && go) ? '0 : rp_q + AW'(pop_ok);
    cnt_d = (state_q == IDLE && go) ? 5'd0 : cnt_q + 5'(push) - 5'(pop_ok);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      next_q <= '0;
      end_q <= '0;
      loc_q <= '0;
      mc_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q <= next_d;
      end_q <= end_d;
      loc_q <= loc_d;
      mc_q <= mc_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ready_q <= state_d == LAUNCH;
      done_q <= state_d == FINISH;
      busy_q <= state_d != IDLE;
    end
  end
  always_ff @(posedge clock) if (push) mem[wp_q] <= loc_q;
  assign srch_ready = ready_q;
  assign srch_start = next_q;
  assign job_done = done_q;
  assign busy = busy_q;
  assign match_count = mc_q;
  assign overflow = ovf_q;
  assign err_flag = err_q;
  assign fifo_count = cnt_q;
  assign loc_valid = cnt_q != 5'd0;
  assign loc_out = loc_valid ? mem[rp_q] : 16'h0;
endmodule
